ascensor_fsm: RTL and testbench
===============================

ASCENSOR_FSM -- requirements
Module: ascensor_fsm

Interface
REQ-001 SHALL have parameter TICKS_PISO, default 50_000_000, clock cycles to travel one floor (>=2).
REQ-002 SHALL have parameter TICKS_PUERTA, default 100_000_000, clock cycles doors stay open (>=2).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port llamada  input  4  floor call requests, bit i = floor i, level-sampled each cycle.
REQ-006 SHALL have port piso  output  2  current floor 0..3.
REQ-007 SHALL have port direccion  output  2  00 stopped, 01 up, 10 down; 11 never driven.
REQ-008 SHALL have port puertas_abiertas  output  1  high while doors open.
REQ-009 SHALL have port pendientes  output  4  latched unserved calls.

Function
REQ-010 SHALL implement states REPOSO, MOVIENDO, PUERTA; all outputs registered.
REQ-011 SHALL set pendientes[i] the cycle after llamada[i] is sampled high, except when in PUERTA with piso==i (call ignored, door timer restarts).
REQ-012 SHALL clear pendientes[piso] on the edge entering PUERTA; a same-cycle llamada for that floor SHALL not re-set it.
REQ-013 In REPOSO, if pendientes[piso] set -> PUERTA next cycle, direccion 00.
REQ-014 In REPOSO otherwise, choose target direction: keep last travel direction if any call lies beyond piso in it; else the other direction if any call there; else stay REPOSO, direccion 00.
REQ-015 Entering MOVIENDO SHALL drive direccion 01/10 and load travel counter to 0.
REQ-016 In MOVIENDO, counter increments each cycle; when it reaches TICKS_PISO-1, piso SHALL step +/-1 on that edge and counter return to 0 (piso changes exactly TICKS_PISO cycles after leaving previous floor).
REQ-017 On the floor-step edge, if pendientes[new piso] set -> PUERTA; else if any call remains further in direccion -> stay MOVIENDO; else -> REPOSO, direccion 00.
REQ-018 SHALL never step above floor 3 or below floor 0; no wrap-around of piso.
REQ-019 PUERTA SHALL hold puertas_abiertas high for exactly TICKS_PUERTA cycles (plus restarts per REQ-011), direccion retains the arriving travel value, then -> REPOSO with puertas_abiertas low.
REQ-020 Door counter and travel counter SHALL be sized to hold their parameter; no overflow.
REQ-021 Calls for other floors arriving during MOVIENDO/PUERTA SHALL be latched and served by REQ-014/017 ordering (SCAN).
REQ-022 puertas_abiertas and direccion != 00 SHALL never coexist except in PUERTA per REQ-019; doors never open while piso changes.

Reset
REQ-023 rst_n low SHALL immediately force REPOSO, piso 0, direccion 00, puertas_abiertas 0, pendientes 0000, counters 0, last direction up; including mid-travel or door-open.
REQ-024 First llamada sampling SHALL occur on the first rising clk after rst_n deasserts.

Verification (TICKS_PISO=4, TICKS_PUERTA=3)
REQ-025 Reset, llamada=0001 one cycle -> pendientes 0001 next cycle, PUERTA following cycle, puertas_abiertas high 3 cycles, pendientes 0000, back to REPOSO.
REQ-026 From piso 0, llamada=1000 pulse -> direccion 01, piso 1/2/3 at 4-cycle intervals, doors open at 3 for 3 cycles, then direccion 00.
REQ-027 At piso 0 moving up to 3, inject llamada=0100 before reaching floor 2 -> stops at 2 (doors 3 cycles), continues to 3; pendientes clears 0100 then 1000.
REQ-028 At piso 2 idle, simultaneous llamada=1001, last direction up -> serves 3 first, then travels down to 0.
REQ-029 In PUERTA at piso 1, llamada=0010 held 2 cycles -> door interval extended, pendientes stays 0000.
REQ-030 Assert rst_n low mid-travel between floors 1 and 2 -> all outputs to reset values asynchronously; no floor step after release without new call.

Source files
------------

// File: rtl/ascensor_fsm.sv
// Four-floor elevator controller: latches floor calls and serves them in SCAN order,
// stepping one floor every TICKS_PISO cycles and holding doors open for TICKS_PUERTA cycles.
module ascensor_fsm #(
  parameter int TICKS_PISO   = 50_000_000,
  parameter int TICKS_PUERTA = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] llamada,
  output logic [1:0] piso,
  output logic [1:0] direccion,
  output logic       puertas_abiertas,
  output logic [3:0] pendientes
);

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    MOVIENDO = 2'd1,
    PUERTA   = 2'd2
  } estado_t;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  localparam int PW = $clog2(TICKS_PISO);
  localparam int DW = $clog2(TICKS_PUERTA);
  localparam logic [PW-1:0] PISO_MAX   = PW'(TICKS_PISO - 1);
  localparam logic [DW-1:0] PUERTA_MAX = DW'(TICKS_PUERTA - 1);

  estado_t       estado, estado_next;
  logic [1:0]    piso_next, piso_paso, direccion_next;
  logic [3:0]    pend_next;
  logic          puertas_next;
  logic [PW-1:0] cnt_piso, cnt_piso_next;
  logic [DW-1:0] cnt_puerta, cnt_puerta_next;
  logic          ultima_subida, ultima_subida_next;
  logic          hay_arriba, hay_abajo, subir, bajar, hay_mas_alla;

  // Bits strictly above / strictly below floor p.
  function automatic logic [3:0] mask_arriba(input logic [1:0] p);
    return 4'(4'b1110 << p);
  endfunction

  function automatic logic [3:0] mask_abajo(input logic [1:0] p);
    return 4'((4'b0001 << p) - 4'b0001);
  endfunction

  // All state is registered; outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado           <= REPOSO;
      piso             <= 2'd0;
      direccion        <= DIR_STOP;
      puertas_abiertas <= 1'b0;
      pendientes       <= 4'b0000;
      cnt_piso         <= '0;
      cnt_puerta       <= '0;
      ultima_subida    <= 1'b1;
    end else begin
      estado           <= estado_next;
      piso             <= piso_next;
      direccion        <= direccion_next;
      puertas_abiertas <= puertas_next;
      pendientes       <= pend_next;
      cnt_piso         <= cnt_piso_next;
      cnt_puerta       <= cnt_puerta_next;
      ultima_subida    <= ultima_subida_next;
    end
  end

  // Next-state, counters and call latching.
  always_comb begin
    estado_next        = estado;
    piso_next          = piso;
    cnt_piso_next      = cnt_piso;
    cnt_puerta_next    = cnt_puerta;
    ultima_subida_next = ultima_subida;
    pend_next          = pendientes | llamada;
    piso_paso          = piso;
    hay_mas_alla       = 1'b0;

    hay_arriba = |(pendientes & mask_arriba(piso));
    hay_abajo  = |(pendientes & mask_abajo(piso));
    subir      = hay_arriba && (ultima_subida || !hay_abajo);
    bajar      = hay_abajo && !subir;

    case (estado)
      REPOSO: begin
        if (pendientes[piso]) begin
          estado_next     = PUERTA;
          cnt_puerta_next = '0;
          pend_next[piso] = 1'b0;
        end else if (subir || bajar) begin
          estado_next        = MOVIENDO;
          cnt_piso_next      = '0;
          ultima_subida_next = subir;
        end
      end

      MOVIENDO: begin
        if (cnt_piso == PISO_MAX) begin
          if (direccion == DIR_UP) begin
            piso_paso    = (piso != 2'd3) ? piso + 2'd1 : piso;
            hay_mas_alla = |(pendientes & mask_arriba(piso_paso));
          end else begin
            piso_paso    = (piso != 2'd0) ? piso - 2'd1 : piso;
            hay_mas_alla = |(pendientes & mask_abajo(piso_paso));
          end
          piso_next     = piso_paso;
          cnt_piso_next = '0;
          if (pendientes[piso_paso]) begin
            estado_next          = PUERTA;
            cnt_puerta_next      = '0;
            pend_next[piso_paso] = 1'b0;
          end else if (!hay_mas_alla) begin
            estado_next = REPOSO;
          end
        end else begin
          cnt_piso_next = cnt_piso + PW'(1);
        end
      end

      PUERTA: begin
        // A call for the floor we are standing on just keeps the doors open longer.
        if (llamada[piso]) begin
          pend_next[piso] = 1'b0;
          cnt_puerta_next = '0;
        end else if (cnt_puerta == PUERTA_MAX) begin
          estado_next = REPOSO;
        end else begin
          cnt_puerta_next = cnt_puerta + DW'(1);
        end
      end

      default: estado_next = REPOSO;
    endcase
  end

  // Output values for the next cycle; direction is only chosen when leaving REPOSO.
  always_comb begin
    puertas_next = (estado_next == PUERTA);
    if (estado_next == REPOSO) begin
      direccion_next = DIR_STOP;
    end else if (estado == REPOSO && estado_next == MOVIENDO) begin
      direccion_next = ultima_subida_next ? DIR_UP : DIR_DOWN;
    end else begin
      direccion_next = direccion;
    end
  end

endmodule

// File: tb/tb_ascensor_fsm.sv
// Self-checking bench for ascensor_fsm with TICKS_PISO=4, TICKS_PUERTA=3:
// cycle-by-cycle vector tables plus directed sequences for SCAN order, door extension and reset.
module tb_ascensor_fsm;

  logic       clk;
  logic       rst_n;
  logic [3:0] llamada;
  logic [1:0] piso;
  logic [1:0] direccion;
  logic       puertas_abiertas;
  logic [3:0] pendientes;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit         do_reset;
    logic [3:0] llamada;
    logic [1:0] piso;
    logic [1:0] dir;
    logic       doors;
    logic [3:0] pend;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  ascensor_fsm #(.TICKS_PISO(4), .TICKS_PUERTA(3)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .llamada          (llamada),
    .piso             (piso),
    .direccion        (direccion),
    .puertas_abiertas (puertas_abiertas),
    .pendientes       (pendientes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input bit r, input logic [3:0] ll, input logic [1:0] p,
                        input logic [1:0] d, input logic dr, input logic [3:0] pe, input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.do_reset = r && (i == 0);
      v.llamada  = ll;
      v.piso     = p;
      v.dir      = d;
      v.doors    = dr;
      v.pend     = pe;
      vecs.push_back(v);
    end
  endtask

  task automatic checkVal(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic doReset();
    llamada = 4'b0000;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic checkOutput(input int idx);
    vec_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL vec%0d: scoreboard empty", idx);
      return;
    end
    e = sb.pop_front();
    n_checks++;
    if (piso !== e.piso || direccion !== e.dir || puertas_abiertas !== e.doors ||
        pendientes !== e.pend) begin
      n_errors++;
      $display("[TB] FAIL vec%0d: got piso=%0d dir=%b doors=%b pend=%b, expected piso=%0d dir=%b doors=%b pend=%b",
               idx, piso, direccion, puertas_abiertas, pendientes, e.piso, e.dir, e.doors, e.pend);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    if (v.do_reset) doReset();
    llamada = v.llamada;
    sb.push_back(v);
    @(posedge clk);
    #1;
    checkOutput(idx);
  endtask

  // Advance edge by edge until doors reach lvl; returns the edge count or -1 on timeout.
  task automatic waitDoors(input logic lvl, input int max_cycles, input string name,
                           output int cycles);
    cycles = 0;
    while (puertas_abiertas !== lvl && cycles < max_cycles) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (puertas_abiertas !== lvl) begin
      checkVal({name, "_timeout"}, int'(puertas_abiertas), int'(lvl));
      cycles = -1;
    end
  endtask

  task automatic pulseCall(input logic [3:0] ll);
    llamada = ll;
    @(posedge clk);
    #1;
    llamada = 4'b0000;
  endtask

  initial begin
    int cyc;
    int open_cycles;
    rst_n   = 1'b0;
    llamada = 4'b0000;

    // Reset values
    doReset();
    #1;
    checkVal("reset_piso", int'(piso), 0);
    checkVal("reset_dir", int'(direccion), 0);
    checkVal("reset_doors", int'(puertas_abiertas), 0);
    checkVal("reset_pend", int'(pendientes), 0);

    // Call at the current floor: latch, open for 3 cycles, close
    addVec(1'b1, 4'b0001, 2'd0, 2'b00, 1'b0, 4'b0001, 1);
    addVec(1'b0, 4'b0000, 2'd0, 2'b00, 1'b1, 4'b0000, 3);
    addVec(1'b0, 4'b0000, 2'd0, 2'b00, 1'b0, 4'b0000, 2);
    // Travel 0 -> 3, one floor every 4 cycles
    addVec(1'b0, 4'b1000, 2'd0, 2'b00, 1'b0, 4'b1000, 1);
    addVec(1'b0, 4'b0000, 2'd0, 2'b01, 1'b0, 4'b1000, 4);
    addVec(1'b0, 4'b0000, 2'd1, 2'b01, 1'b0, 4'b1000, 4);
    addVec(1'b0, 4'b0000, 2'd2, 2'b01, 1'b0, 4'b1000, 4);
    addVec(1'b0, 4'b0000, 2'd3, 2'b01, 1'b1, 4'b0000, 3);
    addVec(1'b0, 4'b0000, 2'd3, 2'b00, 1'b0, 4'b0000, 2);
    // Intermediate call for floor 2 picked up on the way to 3
    addVec(1'b1, 4'b1000, 2'd0, 2'b00, 1'b0, 4'b1000, 1);
    addVec(1'b0, 4'b0000, 2'd0, 2'b01, 1'b0, 4'b1000, 4);
    addVec(1'b0, 4'b0000, 2'd1, 2'b01, 1'b0, 4'b1000, 1);
    addVec(1'b0, 4'b0100, 2'd1, 2'b01, 1'b0, 4'b1100, 1);
    addVec(1'b0, 4'b0000, 2'd1, 2'b01, 1'b0, 4'b1100, 2);
    addVec(1'b0, 4'b0000, 2'd2, 2'b01, 1'b1, 4'b1000, 3);
    addVec(1'b0, 4'b0000, 2'd2, 2'b00, 1'b0, 4'b1000, 1);
    addVec(1'b0, 4'b0000, 2'd2, 2'b01, 1'b0, 4'b1000, 4);
    addVec(1'b0, 4'b0000, 2'd3, 2'b01, 1'b1, 4'b0000, 3);
    addVec(1'b0, 4'b0000, 2'd3, 2'b00, 1'b0, 4'b0000, 1);

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    // SCAN: idle at 2 with last direction up, calls for 3 and 0 -> serve 3 first
    doReset();
    pulseCall(4'b0100);
    waitDoors(1'b1, 40, "scan_reach2_open", cyc);
    checkVal("scan_at2_piso", int'(piso), 2);
    waitDoors(1'b0, 10, "scan_reach2_close", cyc);
    pulseCall(4'b1001);
    waitDoors(1'b1, 20, "scan_first_open", cyc);
    checkVal("scan_first_latency", cyc + 1, 6);
    checkVal("scan_first_piso", int'(piso), 3);
    checkVal("scan_first_dir", int'(direccion), 1);
    checkVal("scan_first_pend", int'(pendientes), 4'b0001);
    waitDoors(1'b0, 10, "scan_first_close", cyc);
    checkVal("scan_first_close_dir", int'(direccion), 0);
    waitDoors(1'b1, 30, "scan_second_open", cyc);
    checkVal("scan_down_cycles", cyc, 13);
    checkVal("scan_second_piso", int'(piso), 0);
    checkVal("scan_second_dir", int'(direccion), 2);
    checkVal("scan_second_pend", int'(pendientes), 0);

    // Door extension: call for the open floor held 2 cycles
    doReset();
    pulseCall(4'b0010);
    waitDoors(1'b1, 20, "ext_open", cyc);
    checkVal("ext_piso", int'(piso), 1);
    open_cycles = 1;
    llamada = 4'b0010;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checkVal("ext_pend_held", int'(pendientes), 0);
      checkVal("ext_doors_held", int'(puertas_abiertas), 1);
      open_cycles++;
    end
    llamada = 4'b0000;
    waitDoors(1'b0, 10, "ext_close", cyc);
    open_cycles += cyc - 1;
    checkVal("ext_open_cycles", open_cycles, 5);
    checkVal("ext_pend_after", int'(pendientes), 0);

    // Asynchronous reset mid-travel between floors 1 and 2
    doReset();
    pulseCall(4'b1000);
    repeat (7) @(posedge clk);
    #3;
    checkVal("midtravel_piso", int'(piso), 1);
    checkVal("midtravel_dir", int'(direccion), 1);
    rst_n = 1'b0;
    #1;
    checkVal("async_piso", int'(piso), 0);
    checkVal("async_dir", int'(direccion), 0);
    checkVal("async_doors", int'(puertas_abiertas), 0);
    checkVal("async_pend", int'(pendientes), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      checkVal("post_reset_still", int'({piso, direccion, puertas_abiertas, pendientes}), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
